// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// then subtract the divisor and set the new quotient bit if it fits.
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] dvsr_ext;
    logic           unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit
    // never carries information into the shift.
    assign unused_rem_msb = rem_in[WIDTH];

    // Compare/subtract on the shifted partial remainder.
    always_comb begin
        rem_sh   = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
        dvsr_ext = {1'b0, dvsr};
        rem_out  = rem_sh;
        quo_out  = {quo_in[WIDTH-2:0], 1'b0};
        if (rem_sh >= dvsr_ext) begin
            rem_out    = rem_sh - dvsr_ext;
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done
// handshake. Signed operation is compiled in only when DIVIDER_SIGNED_EN
// is defined; otherwise signed_op is ignored and all divides are unsigned.
// Handshake: start is sampled only in IDLE; busy is high from the accepted
// start until done; done pulses for one cycle with results valid.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             unused_step_msb;

    assign unused_step_msb = step_rem[WIDTH];

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (acc_q),
        .dvsr    (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic dividend_neg, divisor_neg;

    // Operand magnitudes and result sign fix-up for two's-complement mode.
    always_comb begin
        dividend_neg = signed_op & dividend[WIDTH-1];
        divisor_neg  = signed_op & divisor[WIDTH-1];
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg ? -divisor : divisor;
        quo_fix      = neg_q_q ? -step_quo : step_quo;
        rem_fix      = neg_r_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
        neg_q_d      = neg_q_q;
        neg_r_d      = neg_r_q;
        if (state_q == IDLE && start) begin
            neg_q_d = dividend_neg ^ divisor_neg;
            neg_r_d = dividend_neg;
        end
    end

    // Sign flags captured alongside the operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;

    // Unsigned build: operands and results pass straight through.
    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        quo_fix      = step_quo;
        rem_fix      = step_rem[WIDTH-1:0];
    end
`endif

    // Next-state, operand capture, iteration and result registration.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        dvsr_d      = dvsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvsr_d = divisor_mag;
                    acc_d  = dividend_mag;
                    rem_d  = '0;
                    cnt_d  = CNT_W'(WIDTH - 1);
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                acc_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    dbz_d       = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            dvsr_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            dvsr_q      <= dvsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == CALC) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32). The reference model uses
// plain 64-bit arithmetic; signed expectations follow DIVIDER_SIGNED_EN.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_op   (signed_op),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        logic use_signed;
`ifdef DIVIDER_SIGNED_EN
        use_signed = s;
`else
        use_signed = 1'b0 & s;
`endif
        dz = (b == '0);
        if (dz) begin
            q = '1;
            r = a;
            return;
        end
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (use_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive one start pulse just after edge E; lat = edges after E until done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        signed_op = s;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) start = 1'b0;
        end while (!done && lat < 100);
        q = quotient;
        r = remainder;
        dz = div_by_zero;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++; if (quotient !== '0) begin miscompares++; $display("FAIL reset_q: got %h want 0", quotient); end
        vectors++; if (remainder !== '0) begin miscompares++; $display("FAIL reset_r: got %h want 0", remainder); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        apply_reset();
    endtask

    task automatic test_unsigned();
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat);
        vectors++; if (lat !== W + 1) begin miscompares++; $display("FAIL unsigned_latency: got %0d want %0d", lat, W + 1); end
        vectors++; if (q !== 32'd14) begin miscompares++; $display("FAIL unsigned_q: got %h want %h", q, 32'd14); end
        vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL unsigned_r: got %h want %h", r, 32'd2); end
        vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL unsigned_dbz: got %b want 0", dz); end
        @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL unsigned_busy_after: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL unsigned_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_signed();
        logic [W-1:0] q, r, eq1, er1, eq2, er2;
        logic dz;
        int lat;
`ifdef DIVIDER_SIGNED_EN
        eq1 = 32'hFFFFFFF2; er1 = 32'hFFFFFFFE;
        eq2 = 32'hFFFFFFF2; er2 = 32'd2;
`else
        eq1 = 32'h24924916; er1 = 32'd2;
        eq2 = 32'd0;        er2 = 32'd100;
`endif
        run_op(32'hFFFFFF9C, 32'd7, 1'b1, q, r, dz, lat);
        vectors++; if (q !== eq1) begin miscompares++; $display("FAIL signed_neg_dividend_q: got %h want %h", q, eq1); end
        vectors++; if (r !== er1) begin miscompares++; $display("FAIL signed_neg_dividend_r: got %h want %h", r, er1); end
        run_op(32'd100, 32'hFFFFFFF9, 1'b1, q, r, dz, lat);
        vectors++; if (q !== eq2) begin miscompares++; $display("FAIL signed_neg_divisor_q: got %h want %h", q, eq2); end
        vectors++; if (r !== er2) begin miscompares++; $display("FAIL signed_neg_divisor_r: got %h want %h", r, er2); end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        run_op(32'd5, 32'd0, 1'b0, q, r, dz, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL dz_latency: got %0d want 1", lat); end
        vectors++; if (q !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dz_q: got %h want ffffffff", q); end
        vectors++; if (r !== 32'd5) begin miscompares++; $display("FAIL dz_r: got %h want 5", r); end
        vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b want 1", dz); end
        run_op(32'd6, 32'd3, 1'b0, q, r, dz, lat);
        vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL dz_clear: got %b want 0", dz); end
        vectors++; if (q !== 32'd2) begin miscompares++; $display("FAIL dz_next_q: got %h want 2", q); end
        vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL dz_next_r: got %h want 0", r); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] q, r, eq, er;
        logic dz;
        int lat;
`ifdef DIVIDER_SIGNED_EN
        eq = 32'h80000000; er = 32'd0;
`else
        eq = 32'd0;        er = 32'h80000000;
`endif
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r, dz, lat);
        vectors++; if (q !== eq) begin miscompares++; $display("FAIL overflow_q: got %h want %h", q, eq); end
        vectors++; if (r !== er) begin miscompares++; $display("FAIL overflow_r: got %h want %h", r, er); end
        vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL overflow_dbz: got %b want 0", dz); end
        run_op(32'd0, 32'd9, 1'b0, q, r, dz, lat);
        vectors++; if (lat !== W + 1) begin miscompares++; $display("FAIL zero_dividend_latency: got %0d want %0d", lat, W + 1); end
        vectors++; if ({q, r} !== 64'd0) begin miscompares++; $display("FAIL zero_dividend_qr: got %h want 0", {q, r}); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic dz;
        int lat, ndone;
        run_op(32'd50, 32'd3, 1'b0, q, r, dz, lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 32'd123456;
        divisor = 32'd77;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++; if (quotient !== '0) begin miscompares++; $display("FAIL midreset_q: got %h want 0", quotient); end
        vectors++; if (remainder !== '0) begin miscompares++; $display("FAIL midreset_r: got %h want 0", remainder); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b want 0", done); end
        @(posedge clk);
        #1 reset = 1'b0;
        ndone = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses want 0", ndone); end
        run_op(32'd9, 32'd2, 1'b0, q, r, dz, lat);
        vectors++; if (q !== 32'd4) begin miscompares++; $display("FAIL midreset_next_q: got %h want 4", q); end
        vectors++; if (r !== 32'd1) begin miscompares++; $display("FAIL midreset_next_r: got %h want 1", r); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q1, r1;
        logic b1, b2;
        int lat, ndone, dlat;
        q1 = '0; r1 = '0; b1 = 1'bx; b2 = 1'bx;
        lat = 0; ndone = 0; dlat = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd10;
        signed_op = 1'b0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) start = 1'b0;
            if (lat == 5) begin
                start = 1'b1;
                dividend = 32'd7;
                divisor = 32'd7;
            end
            if (done) begin
                ndone++;
                if (dlat == 0) begin
                    dlat = lat;
                    q1 = quotient;
                    r1 = remainder;
                end
            end
            if (dlat != 0 && lat == dlat + 1) b1 = busy;
            if (dlat != 0 && lat == dlat + 2) begin
                b2 = busy;
                start = 1'b0;
                break;
            end
        end
        vectors++; if (dlat !== W + 1) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", dlat, W + 1); end
        vectors++; if (q1 !== 32'd100) begin miscompares++; $display("FAIL b2b_q: got %h want %h", q1, 32'd100); end
        vectors++; if (r1 !== 32'd0) begin miscompares++; $display("FAIL b2b_r: got %h want 0", r1); end
        vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
        vectors++; if (b1 !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: got busy=%b want 0", b1); end
        vectors++; if (b2 !== 1'b1) begin miscompares++; $display("FAIL b2b_restart: got busy=%b want 1", b2); end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!done && lat < 100);
        vectors++; if (lat !== W) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, W); end
        vectors++; if ({quotient, remainder} !== {32'd1, 32'd0}) begin
            miscompares++; $display("FAIL b2b_second_qr: got %h/%h want 1/0", quotient, remainder);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic s, dz, edz;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       a = 32'h80000000;
                1:       a = 32'd0;
                default: ;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = 32'hFFFFFFFF - W'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er, edz);
            elat = (b == '0) ? 1 : W + 1;
            run_op(a, b, s, q, r, dz, lat);
            vectors++; if (lat !== elat) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, elat); end
            vectors++; if (q !== eq) begin miscompares++; $display("FAIL rand%0d_q (%h/%h s=%b): got %h want %h", i, a, b, s, q, eq); end
            vectors++; if (r !== er) begin miscompares++; $display("FAIL rand%0d_r (%h/%h s=%b): got %h want %h", i, a, b, s, r, er); end
            vectors++; if (dz !== edz) begin miscompares++; $display("FAIL rand%0d_dbz: got %b want %b", i, dz, edz); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
